// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package regfile_sched_pkg;
  localparam int RA_W     = 5;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  typedef logic [RA_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       dest;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// One-hot grant arbiter. Round-robin from ptr when WBSCHED_ROUND_ROBIN_EN is
// defined, otherwise fixed priority with the lowest index winning.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
`ifdef WBSCHED_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] sel;
  logic             found;
`ifdef WBSCHED_ROUND_ROBIN_EN
  logic [IDX_W:0]   sum;
`endif

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sel   = '0;
`ifdef WBSCHED_ROUND_ROBIN_EN
    sum   = '0;
`endif
    for (int k = 0; k < N; k++) begin
`ifdef WBSCHED_ROUND_ROBIN_EN
      // Candidate k steps past ptr, wrapped modulo N.
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      sel = sum[IDX_W-1:0];
`else
      sel = IDX_W'(k);
`endif
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and RAW/WAW scoreboard in front of the register file.
// WBSCHED_ROUND_ROBIN_EN selects round-robin grant; undefined gives fixed priority.
module regfile_wb_sched #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = regfile_sched_pkg::XLEN,
  parameter int RA_W    = regfile_sched_pkg::RA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      wb_valid,
  input  logic [NUM_REQ*RA_W-1:0] wb_dest,
  input  logic [NUM_REQ*XLEN-1:0] wb_data,
  output logic [NUM_REQ-1:0]      wb_ready,
  output logic                    rf_load,
  output logic [RA_W-1:0]         rf_dest,
  output logic [XLEN-1:0]         rf_in,
  input  logic                    iss_valid,
  input  logic [RA_W-1:0]         iss_rs1,
  input  logic [RA_W-1:0]         iss_rs2,
  input  logic [RA_W-1:0]         iss_dest,
  output logic                    iss_stall,
  output logic [regfile_sched_pkg::NUM_REGS-1:0] busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREGS = regfile_sched_pkg::NUM_REGS;

  logic [RA_W-1:0]  dest_arr [NUM_REQ];
  logic [XLEN-1:0]  data_arr [NUM_REQ];
  logic [IDX_W-1:0] gnt_idx;
  logic             any_valid;
  logic [RA_W-1:0]  dest_sel;
  logic [XLEN-1:0]  data_sel;

  logic             rf_load_d, rf_load_q;
  logic [RA_W-1:0]  rf_dest_d, rf_dest_q;
  logic [XLEN-1:0]  rf_in_d,   rf_in_q;
  logic [NREGS-1:0] busy_d,    busy_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign dest_arr[i] = wb_dest[i*RA_W +: RA_W];
    assign data_arr[i] = wb_data[i*XLEN +: XLEN];
  end

  // Handshake: requester i transfers in any cycle where wb_valid[i] && wb_ready[i];
  // the write stage never back-pressures, so some valid requester is always granted.
`ifdef WBSCHED_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_d, ptr_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (wb_valid),
    .ptr (ptr_q),
    .gnt (wb_ready),
    .idx (gnt_idx)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (any_valid) ptr_d = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end
`else
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (wb_valid),
    .gnt (wb_ready),
    .idx (gnt_idx)
  );
`endif

  assign any_valid = |wb_valid;
  assign dest_sel  = dest_arr[gnt_idx];
  assign data_sel  = data_arr[gnt_idx];
  assign iss_stall = iss_valid && (busy_q[iss_rs1] || busy_q[iss_rs2] || busy_q[iss_dest]);

  always_comb begin
    rf_load_d = 1'b0;
    rf_dest_d = rf_dest_q;
    rf_in_d   = rf_in_q;
    if (any_valid) begin
      rf_load_d = (dest_sel != '0);
      rf_dest_d = dest_sel;
      rf_in_d   = data_sel;
    end
    // Clear first so a same-cycle reservation of the written register wins.
    busy_d = busy_q;
    if (rf_load_q) busy_d[rf_dest_q] = 1'b0;
    if (iss_valid && !iss_stall && iss_dest != '0) busy_d[iss_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_load_q <= 1'b0;
      rf_dest_q <= '0;
      rf_in_q   <= '0;
      busy_q    <= '0;
`ifdef WBSCHED_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      rf_load_q <= rf_load_d;
      rf_dest_q <= rf_dest_d;
      rf_in_q   <= rf_in_d;
      busy_q    <= busy_d;
`ifdef WBSCHED_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign rf_load = rf_load_q;
  assign rf_dest = rf_dest_q;
  assign rf_in   = rf_in_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed corner sequences, a stall vector table
// and randomized traffic against a cycle-level reference model.
module tb_regfile_wb_sched;
  localparam int N    = 3;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      wb_valid;
  logic [N*RA_W-1:0] wb_dest;
  logic [N*XLEN-1:0] wb_data;
  logic [N-1:0]      wb_ready;
  logic              rf_load;
  logic [RA_W-1:0]   rf_dest;
  logic [XLEN-1:0]   rf_in;
  logic              iss_valid;
  logic [RA_W-1:0]   iss_rs1, iss_rs2, iss_dest;
  logic              iss_stall;
  logic [31:0]       busy;

  logic [RA_W-1:0]   req_dest [N];
  logic [XLEN-1:0]   req_data [N];

  regfile_wb_sched #(.NUM_REQ(N), .XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_dest(iss_dest),
    .iss_stall(iss_stall), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      wb_dest[i*RA_W +: RA_W] = req_dest[i];
      wb_data[i*XLEN +: XLEN] = req_data[i];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0]           m_busy;
  logic                  m_load;
  logic [RA_W-1:0]       m_dest;
  logic [XLEN-1:0]       m_data;
  int                    m_ptr;
  logic [RA_W+XLEN-1:0]  exp_q[$];

  // last sampled DUT outputs
  logic [N-1:0]    obs_ready;
  logic            obs_stall, obs_load;
  logic [RA_W-1:0] obs_dest;
  logic [31:0]     obs_busy;
  int              last_g;

  typedef struct {
    logic            v;
    logic [RA_W-1:0] rs1, rs2, dest;
    logic            exp_stall;
  } stall_vec_t;
  stall_vec_t stall_tab [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_load = 1'b0; m_dest = '0; m_data = '0; m_ptr = 0;
    exp_q.delete();
  endtask

  // First valid requester found searching upward from ptr, wrapping around.
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [RA_W-1:0] pick_dest(input logic [31:0] b);
    logic [RA_W-1:0] d;
    d = RA_W'($urandom_range(31, 0));
    if (b != 0 && $urandom_range(9, 0) < 6) begin
      for (int t = 0; t < 64; t++) begin
        d = RA_W'($urandom_range(31, 1));
        if (b[d]) break;
      end
    end
    return d;
  endfunction

  // driver: one clock cycle with inputs already applied; compare then advance model
  task automatic step();
    int g;
    logic [N-1:0] exp_ready;
    logic exp_stall;
    logic [RA_W+XLEN-1:0] w;
    @(negedge clk);
    g = model_grant(wb_valid, m_ptr);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_stall = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_dest]);
    obs_ready = wb_ready; obs_stall = iss_stall; obs_load = rf_load;
    obs_dest = rf_dest; obs_busy = busy;
    check("wb_ready", 64'(wb_ready), 64'(exp_ready));
    check("iss_stall", 64'(iss_stall), 64'(exp_stall));
    check("rf_load", 64'(rf_load), 64'(m_load));
    check("rf_dest", 64'(rf_dest), 64'(m_dest));
    check("rf_in", 64'(rf_in), 64'(m_data));
    check("busy", 64'(busy), 64'(m_busy));
    if (rf_load) begin
      if (exp_q.size() == 0) check("rf_write_queue", 64'(exp_q.size()), 64'd1);
      else begin
        w = exp_q.pop_front();
        check("rf_write", 64'({rf_dest, rf_in}), 64'(w));
      end
    end
    if (m_load) m_busy[m_dest] = 1'b0;
    if (iss_valid && !exp_stall && iss_dest != 0) m_busy[iss_dest] = 1'b1;
    if (g >= 0) begin
      m_dest = req_dest[g];
      m_data = req_data[g];
      m_load = (req_dest[g] != 0);
      if (m_load) exp_q.push_back({m_dest, m_data});
`ifdef WBSCHED_ROUND_ROBIN_EN
      m_ptr = (g + 1) % N;
`endif
    end else begin
      m_load = 1'b0;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wb_valid = '0; iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_dest = '0;
    for (int i = 0; i < N; i++) begin
      req_dest[i] = '0; req_data[i] = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] gnt_tab [6];
    logic [RA_W-1:0] dest_tab [6];
    int wait_cnt [N];
    int g2_cnt;

    stall_tab[0] = '{1'b1, 5'd5,  5'd0, 5'd0, 1'b0};
    stall_tab[1] = '{1'b1, 5'd6,  5'd0, 5'd0, 1'b1};
    stall_tab[2] = '{1'b1, 5'd0,  5'd9, 5'd0, 1'b1};
    stall_tab[3] = '{1'b1, 5'd0,  5'd0, 5'd6, 1'b1};
    stall_tab[4] = '{1'b1, 5'd5,  5'd3, 5'd0, 1'b0};
    stall_tab[5] = '{1'b0, 5'd6,  5'd9, 5'd6, 1'b0};
    stall_tab[6] = '{1'b1, 5'd0,  5'd0, 5'd0, 1'b0};
    stall_tab[7] = '{1'b1, 5'd31, 5'd9, 5'd0, 1'b1};
`ifdef WBSCHED_ROUND_ROBIN_EN
    gnt_tab  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    dest_tab = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
`else
    gnt_tab  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    dest_tab = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
`endif

    // power-on reset
    rst = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    check("reset_rf_load", 64'(rf_load), 64'd0);
    check("reset_rf_dest", 64'(rf_dest), 64'd0);
    check("reset_rf_in", 64'(rf_in), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_wb_ready", 64'(wb_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // reset mid-flight
    iss_valid = 1'b1; iss_dest = 5'd4;
    step();
    iss_valid = 1'b0; iss_dest = '0;
    wb_valid = 3'b010; req_dest[1] = 5'd3; req_data[1] = 32'h33;
    @(negedge clk);
    check("midrst_grant", 64'(wb_ready), 64'(3'b010));
    check("midrst_busy_before", 64'(busy), 64'h10);
    #2 rst = 1'b0;
    #1;
    check("midrst_rf_load", 64'(rf_load), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    check("midrst_dropped_write", 64'(rf_load), 64'd0);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // contention: all three valid
    wb_valid = 3'b111;
    req_dest[0] = 5'd1; req_data[0] = 32'hA;
    req_dest[1] = 5'd2; req_data[1] = 32'hB;
    req_dest[2] = 5'd3; req_data[2] = 32'hC;
    for (int c = 0; c < 6; c++) begin
      step();
      check("contend_grant", 64'(obs_ready), 64'(gnt_tab[c]));
      check("contend_rf_load", 64'(rf_load), 64'd1);
      check("contend_rf_dest", 64'(rf_dest), 64'(dest_tab[c]));
    end
    wb_valid = '0;
    step();

    // RAW hazard on x5
    iss_valid = 1'b1; iss_dest = 5'd5; iss_rs1 = '0; iss_rs2 = '0;
    step();
    iss_rs1 = 5'd5; iss_dest = 5'd6;
    for (int c = 0; c < 3; c++) begin
      step();
      check("raw_stall_hold", 64'(obs_stall), 64'd1);
    end
    wb_valid = 3'b100; req_dest[2] = 5'd5; req_data[2] = 32'h55;
    step();
    wb_valid = '0;
    step();
    check("raw_clear_cycle_load", 64'(obs_load), 64'd1);
    check("raw_clear_cycle_dest", 64'(obs_dest), 64'd5);
    check("raw_clear_cycle_stall", 64'(obs_stall), 64'd1);
    step();
    check("raw_released", 64'(obs_stall), 64'd0);
    iss_rs1 = '0; iss_dest = 5'd9;
    step();

    // stall vector table against busy = {x6, x9}
    for (int t = 0; t < 8; t++) begin
      iss_valid = stall_tab[t].v; iss_rs1 = stall_tab[t].rs1;
      iss_rs2 = stall_tab[t].rs2; iss_dest = stall_tab[t].dest;
      step();
      check("tab_stall", 64'(obs_stall), 64'(stall_tab[t].exp_stall));
      check("tab_busy", 64'(obs_busy), 64'h240);
    end
    clear_inputs();

    // same-cycle set and clear of x7
    wb_valid = 3'b001; req_dest[0] = 5'd7; req_data[0] = 32'h77;
    step();
    wb_valid = '0; iss_valid = 1'b1; iss_dest = 5'd7;
    step();
    check("setclr_load", 64'(obs_load), 64'd1);
    check("setclr_dest", 64'(obs_dest), 64'd7);
    check("setclr_stall", 64'(obs_stall), 64'd0);
    iss_valid = 1'b0; iss_dest = '0;
    step();
    check("setclr_busy7", 64'(obs_busy[7]), 64'd1);

    // x0 handling
    wb_valid = 3'b001; req_dest[0] = 5'd0; req_data[0] = 32'hFFFF_FFFF;
    step();
    check("x0_ready", 64'(obs_ready), 64'(3'b001));
    wb_valid = '0; iss_valid = 1'b1; iss_rs1 = '0; iss_rs2 = '0; iss_dest = '0;
    step();
    check("x0_no_load", 64'(obs_load), 64'd0);
    check("x0_no_stall", 64'(obs_stall), 64'd0);
    iss_valid = 1'b0;
    step();
    check("x0_busy_same", 64'(obs_busy), 64'h2C0);

    // requesters 0 and 2 held valid
    wb_valid = 3'b101; req_dest[0] = 5'd1; req_dest[2] = 5'd2;
    g2_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (obs_ready[2]) g2_cnt++;
`ifndef WBSCHED_ROUND_ROBIN_EN
      check("fixed_prio_grant", 64'(obs_ready), 64'(3'b001));
`endif
    end
`ifdef WBSCHED_ROUND_ROBIN_EN
    check("rr_share_req2", 64'(g2_cnt), 64'd2);
`endif
    clear_inputs();

    // randomized traffic
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!wb_valid[i] && $urandom_range(1, 0) == 1) begin
          wb_valid[i] = 1'b1;
          req_dest[i] = pick_dest(m_busy);
          req_data[i] = $urandom();
        end
      end
      iss_valid = 1'($urandom_range(1, 0));
      iss_rs1   = RA_W'($urandom_range(31, 0));
      iss_rs2   = RA_W'($urandom_range(31, 0));
      iss_dest  = RA_W'($urandom_range(31, 0));
      step();
      for (int i = 0; i < N; i++) begin
        if (last_g == i) begin
`ifdef WBSCHED_ROUND_ROBIN_EN
          check("starvation_bound", 64'(wait_cnt[i] < N), 64'd1);
`endif
          wait_cnt[i] = 0;
          wb_valid[i] = 1'b0;
        end else if (wb_valid[i]) begin
          wait_cnt[i]++;
        end
      end
    end
    clear_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Writeback scheduler and scoreboard in front of the 32x32 register file.
- Shares the single register-file write port among NUM_REQ writeback requesters (ALU, load unit, mul/div) with a valid/ready handshake.
- Drives the write port through one registered stage.
- Tracks in-flight destination registers so issue logic stalls on RAW/WAW hazards.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
RA_W, 5, register address width (32 registers; x0 hardwired zero)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
wb_valid  input  NUM_REQ  requester i has a result
wb_dest  input  NUM_REQ*RA_W  destination of requester i, slice i
wb_data  input  NUM_REQ*XLEN  result of requester i, slice i
wb_ready  output  NUM_REQ  one-hot grant; a transfer occurs when wb_valid[i] && wb_ready[i]
rf_load  output  1  register-file write enable
rf_dest  output  RA_W  register-file write address
rf_in  output  XLEN  register-file write data
iss_valid  input  1  issue stage presents an instruction
iss_rs1  input  RA_W  source 1
iss_rs2  input  RA_W  source 2
iss_dest  input  RA_W  destination to reserve
iss_stall  output  1  instruction must hold; no reservation made
busy  output  32  scoreboard bits; bit 0 is always 0

Behaviour:
- Reset (rst low, asynchronous): rf_load=0, rf_dest=0, rf_in=0, busy=0, arbitration pointer=0. All outputs are held while rst is low, and any in-flight write is dropped.
- Grant (combinational):
  - wb_ready is one-hot among asserted wb_valid bits, or all zero when none are valid.
  - The write stage always accepts, so exactly one transfer occurs per cycle whenever any wb_valid is high.
- Arbitration:
  - Round-robin: search starts at index ptr. After a transfer by requester g, ptr <= (g+1) mod NUM_REQ.
  - With no transfer, ptr holds.
- Write stage, registered with 1-cycle latency:
  - Cycle after a transfer: rf_load=1 if the granted wb_dest != 0, else 0. rf_dest and rf_in carry the granted dest and data.
  - With no transfer, rf_load=0; rf_dest and rf_in hold their values.
- Scoreboard:
  - Set: busy[iss_dest] <= 1 when iss_valid && !iss_stall && iss_dest != 0.
  - Clear: busy[rf_dest] <= 0 in the cycle rf_load=1. The register file's write-through bypass makes the value readable in that same cycle, so the clear happens then.
  - Set and clear of the same register in the same cycle: set wins.
  - iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_dest]). busy[0] is always 0, so x0 never stalls.
  - A stalled instruction reserves nothing. It re-evaluates every cycle.
- Requester contract:
  - While wb_valid[i]=1 and wb_ready[i]=0, slice i must hold its dest and data.
  - A requester may deassert only after its transfer.
  - A write to a register that is not busy is legal and is written. The scoreboard is unaffected unless the register is marked busy.
- A transfer to dest 0 is accepted and consumes a grant, but produces no register write.
- Starvation bound: any valid requester is granted within NUM_REQ cycles.

Optional Feature:
WBSCHED_ROUND_ROBIN_EN
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, lowest index wins. ptr is removed, and the starvation bound no longer applies.
- Scoreboard and write stage are identical in both builds.

Decomposition:
- Package regfile_sched_pkg holds:
  - RA_W and XLEN constants.
  - typedef reg_addr_t (logic [RA_W-1:0]).
  - typedef wb_req_t struct {dest, data}.
  - A NUM_REGS=32 constant.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr. Outputs: one-hot gnt[N] and the encoded index.
  - Fixed-priority mode is selected by the macro.
  - Scoreboard and write stage stay in the top module.

Test Plan:
1. Reset mid-flight: busy=0x0000_0010 with a transfer just granted, pull rst low -> immediately rf_load=0 and busy=0; after release, the first grant goes to requester 0.
2. Contention: all three valid for 6 cycles (dest 1,2,3; data 0xA,0xB,0xC) -> grant order 0,1,2,0,1,2; rf_load and rf_dest appear one cycle after each grant.
3. RAW hazard: issue dest=5 (accepted), then issue rs1=5 -> iss_stall=1 until the cycle rf_load=1 with rf_dest=5; the next cycle iss_stall=0.
4. Same-cycle set and clear: rf_load with rf_dest=7 while an issue reserves dest=7 -> busy[7] stays 1.
5. x0 handling: wb_dest=0 with data 0xFFFF_FFFF -> wb_ready=1, next cycle rf_load=0; issue with dest=0 and rs1=0 -> iss_stall=0 and busy unchanged.
6. Macro undefined: requesters 0 and 2 held valid -> requester 0 is granted every cycle and requester 2 never is.
